// File: rtl/sub32_seq.sv
// ---------------------------------------------------------------------------
// sub32_seq -- multi-cycle W-bit subtractor built around one H-bit adder.
//
// The difference a - b is formed as a + ~b + 1 in two halves. The low half
// is computed first and its carry is kept for the high half. One accepted
// operand pair therefore takes three clock edges to produce a result:
//   IDLE --accept--> LO --> HI --> DONE --out_ready--> IDLE
//
// Ports
//   clk        in   1   sole clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   a/b carry a valid operand pair
//   in_ready   out  1   high only in IDLE; a pair is taken when both are 1
//   a          in   W   minuend (unsigned or two's complement)
//   b          in   W   subtrahend
//   out_valid  out  1   high only in DONE; diff/borrow/ovf are valid
//   out_ready  in   1   consumer takes the result (looked at only in DONE)
//   diff       out  W   a - b modulo 2^W
//   borrow     out  1   1 iff a < b as unsigned numbers
//   ovf        out  1   signed overflow of a - b
//
// W must be even and at least 4. The result registers keep the last result
// after the block returns to IDLE, until the next operation overwrites them.
// ---------------------------------------------------------------------------
module sub32_seq #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] diff,
   output logic         borrow,
   output logic         ovf
);

   localparam int H = W / 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t         state_q, state_d;

   // Operands captured at accept; they stay put until the next accept.
   logic [W-1:0]   a_q, b_q;
   // Carry out of the low half, consumed by the high half.
   logic           carry_q;

   // The one shared H-bit adder and its operand muxes.
   logic [H-1:0]   add_x, add_y;
   logic           add_cin;
   logic [H:0]     add_sum;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   // NOTE: every clocked process uses non-blocking (<=) assignments so all
   // registers update together from values sampled before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next state and handshake outputs
   // ------------------------------------------------------------------
   // NOTE: each signal driven here gets a default before the case so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = LO;
         end
         LO:   state_d = HI;
         HI:   state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Shared adder: low half with carry-in 1 in LO, high half with the
   // stored carry in HI. Outside those states its result is unused.
   // ------------------------------------------------------------------
   always_comb begin
      add_x   = a_q[H-1:0];
      add_y   = ~b_q[H-1:0];
      add_cin = 1'b1;
      if (state_q == HI) begin
         add_x   = a_q[W-1:H];
         add_y   = ~b_q[W-1:H];
         add_cin = carry_q;
      end
   end

   assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{H{1'b0}}, add_cin};

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   // NOTE: the operand and result registers are reset along with the FSM
   // so a reset leaves zeros on the outputs rather than a stale result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         diff    <= '0;
         borrow  <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q <= a;
                  b_q <= b;
               end
            end
            LO: begin
               diff[H-1:0] <= add_sum[H-1:0];
               carry_q     <= add_sum[H];
            end
            HI: begin
               diff[W-1:H] <= add_sum[H-1:0];
               // No carry out of a + ~b + 1 means the subtraction borrowed.
               borrow      <= ~add_sum[H];
               // Overflow only when the operand signs differ and the
               // result sign differs from the minuend's sign.
               ovf         <= (a_q[W-1] ^ b_q[W-1]) & (add_sum[H-1] ^ a_q[W-1]);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sub32_seq.md
SUB32_SEQ -- requirements
Module: sub32_seq

Interface
REQ-001 Parameter: W, default 32, operand/result width; SHALL be even and >= 4; datapath half-width H = W/2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand pair a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  W  minuend, two's complement or unsigned.
REQ-007 b  input  W  subtrahend.
REQ-008 out_valid  output  1  diff/borrow/ovf are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 diff  output  W  a - b modulo 2^W.
REQ-011 borrow  output  1  unsigned borrow: 1 iff a < b (unsigned).
REQ-012 ovf  output  1  signed overflow of a - b.

Function
REQ-013 The block SHALL be a four-state FSM: IDLE, LO, HI, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept: on an edge with in_valid=1 in IDLE, the block SHALL register a and b and move IDLE->LO; with in_valid=0 it SHALL stay in IDLE.
REQ-016 LO: one H-bit add of a[H-1:0] + ~b[H-1:0] + 1; store the low result in diff[H-1:0], carry in an internal register; LO->HI unconditionally.
REQ-017 HI: one H-bit add of a[W-1:H] + ~b[W-1:H] + stored carry; store diff[W-1:H]; borrow = NOT(carry out); ovf = (a[W-1] != b[W-1]) AND (diff[W-1] != a[W-1]); HI->DONE unconditionally.
REQ-018 Only a single H-bit adder SHALL exist in the datapath; it is shared by LO and HI.
REQ-019 Latency: accept at edge E0, out_valid SHALL be 1 in the cycle after edge E2 (3 edges).
REQ-020 DONE: out_valid=1; diff, borrow and ovf SHALL hold stable while out_ready=0 (backpressure of any length).
REQ-021 On an edge in DONE with out_ready=1, the block SHALL return to IDLE; in_ready SHALL be 1 in the following cycle; no same-cycle accept in DONE.
REQ-022 a, b, in_valid SHALL be ignored in LO, HI and DONE; registered operands SHALL not change until the next accept.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 Throughput: at most one result per 4 cycles with out_ready tied to 1.
REQ-025 diff, borrow and ovf SHALL retain the last result after returning to IDLE until overwritten in LO/HI.

Reset
REQ-026 rst_n=0 SHALL force IDLE immediately, regardless of clk.
REQ-027 During and after reset: in_ready=1, out_valid=0, diff=0, borrow=0, ovf=0, internal carry=0, registered operands=0.
REQ-028 Reset asserted in LO, HI or DONE SHALL abandon the operation; no result for it is ever presented.

Verification
REQ-029 a=5, b=3, out_ready=1 -> out_valid 3 edges after accept, diff=0x00000002, borrow=0, ovf=0.
REQ-030 a=3, b=5 -> diff=0xFFFFFFFE, borrow=1, ovf=0.
REQ-031 a=0x80000000, b=1 -> diff=0x7FFFFFFF, borrow=0, ovf=1; a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, borrow=1, ovf=1.
REQ-032 a=0x00010000, b=1 -> diff=0x0000FFFF, borrow=0 (cross-half borrow); a=b=0xDEADBEEF -> diff=0, borrow=0, ovf=0.
REQ-033 Backpressure: out_ready=0 for 10 cycles with a/b/in_valid toggling -> out_valid stays 1, outputs unchanged, in_ready stays 0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-034 rst_n pulsed low mid-cycle in HI -> in_ready=1, out_valid=0, diff=0 immediately; next accept (a=10, b=4) -> diff=0x00000006 with normal latency.
